alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencing and sharing controller for the single 32-bit ALU. Arbitrates between two requesters (port 0: execute stage, port 1: address/auxiliary unit), issues one operation per grant to the ALU, and registers the result. Owns the architectural NZCV flag register and feeds the carry and overflow flags back to the ALU as `Cin` and `V_flag`. Returns each result to its requester over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `req_valid` input 2: per-requester request valid
- `req_ready` output 2: per-requester request accepted this cycle (one-hot or zero)
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input DATA_WIDTH each: operands
- `req0_ctrl`, `req1_ctrl` input 4: ALUControl code
- `req0_fu`, `req1_fu` input 1: FlagUpdate for that operation
- `rsp_valid` output 2: one-hot result valid, owner's bit only
- `rsp_ready` input 2: per-requester result accept
- `rsp_result` output DATA_WIDTH: registered result
- `rsp_cout` output 1: registered carry-out of the operation
- `alu_a`, `alu_b` output DATA_WIDTH: ALU operand drive
- `alu_ctrl` output 4; `alu_fu` output 1; `alu_cin` output 1; `alu_vflag` output 1
- `alu_result` input DATA_WIDTH; `alu_cout`, `alu_n`, `alu_z`, `alu_c`, `alu_v` input 1
- `flags_nzcv` output 4: architectural flags {N,Z,C,V}

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, grant one requester and assert its `req_ready` combinationally in the same cycle. Capture that requester's operands, ctrl, and fu, plus the owner index. Go to EXEC.
- EXEC (exactly 1 cycle): drive `alu_a`/`alu_b`/`alu_ctrl` from the captured values. Drive `alu_fu` = captured fu, `alu_cin` = flags C, and `alu_vflag` = flags V.
  - At the clock edge, capture `alu_result` and `alu_cout` into the rsp registers.
  - If fu = 1, also load flags_nzcv <= {alu_n, alu_z, alu_c, alu_v}. If fu = 0, the flags are unchanged.
  - Go to RESP.
- RESP: assert `rsp_valid[owner]` and hold result stable until `rsp_ready[owner]` = 1.
  - On handshake with no `req_valid`, go to IDLE.
  - On handshake with any `req_valid`, perform a new grant in the same cycle (as in IDLE) and go to EXEC.
- Outside EXEC: `alu_a`, `alu_b`, `alu_ctrl`, `alu_fu` are driven to 0. `alu_cin`/`alu_vflag` always reflect flags C/V.
- Round-robin arbitration: a `last` pointer records the most recent grantee. When both requesters are valid, grant the one not equal to `last`. When one is valid, grant it. `last` updates on every grant.
- `rsp_ready` on the non-owner bit is ignored. `req_valid` is sampled only in IDLE or at the RESP handshake; requesters must hold the request and its operands until `req_ready`.
- Width rules: result is DATA_WIDTH; cout is bit DATA_WIDTH of the ALU sum, passed through unmodified.

## Timing
- Reset (`rst` = 1 at an edge): state IDLE; `flags_nzcv` = 4'b0000; `last` = 1 (so requester 0 wins the first tie).
  - `rsp_valid` = 0 and `req_ready` = 0.
  - `rsp_result` = 0 and `rsp_cout` = 0.
  - All `alu_*` operand/control outputs = 0.
- Reset mid-operation discards the captured op and any pending response. The flags are not updated.
- Latency: grant at cycle T (`req_ready` high), ALU driven during T+1, `rsp_valid` high from T+2.
- Minimum interval between grants is 2 cycles (back-to-back via the RESP handshake).
- `rsp_result`/`rsp_cout` are stable for the whole RESP period.
- A flag update from op k is visible as `alu_cin` for op k+1 even when k+1 is granted at the handshake edge. This holds because the flags load at the end of EXEC.

## Configuration
- `ALU_SHARE_FIXED_PRIO_EN` defined: fixed priority; requester 0 always wins when both are valid, and `last` is unused.
- Undefined (default): round-robin as in Operation.

## Test plan
- Reset, then req0 ADD (ctrl 0100, fu = 1) with a = 32'hFFFFFFFF, b = 1:
  - `req_ready` = 01 at T; `rsp_valid` = 01 at T+2.
  - result 0, cout 1, flags_nzcv = 0110.
- Both valid continuously, each issuing SUB 5−3 with fu = 0:
  - grants alternate 0,1,0,1 (round-robin).
  - With `ALU_SHARE_FIXED_PRIO_EN`, grants are all requester 0.
  - Flags unchanged in both cases.
- ADC chaining:
  - Op 1: req0 ADD 32'h80000000 + 32'h80000000, fu = 1 → result 0, C = 1, V = 1.
  - Op 2: granted at the handshake, ADC (0101) 1 + 1 → `alu_cin` = 1, result 3.
- Backpressure: hold `rsp_ready[1]` = 0 for 5 cycles during RESP with req0 valid:
  - result is stable, `req_ready` stays 00.
  - On release, req0 is granted in the same cycle.
- Reset asserted during EXEC of an op with fu = 1:
  - next cycle IDLE, flags = 0000, `rsp_valid` = 00, no stale response after reset.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-requester sequencer for the shared 32-bit ALU; owns the NZCV flag register.
// Optional ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
module alu_share_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req0_ctrl,
  input  logic [3:0]            req1_ctrl,
  input  logic                  req0_fu,
  input  logic                  req1_fu,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_cout,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctrl,
  output logic                  alu_fu,
  output logic                  alu_cin,
  output logic                  alu_vflag,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v,
  output logic [3:0]            flags_nzcv
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [3:0]            ctrl_q;
  logic                  fu_q;
  logic                  owner_q;
  logic [3:0]            flags_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_cout_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic                  last_q;
`endif

  logic                  handshake;
  logic                  grant_fire;
  logic                  grant_idx;
  logic [DATA_WIDTH-1:0] a_d, b_d;
  logic [3:0]            ctrl_d;
  logic                  fu_d;

  assign handshake  = (state_q == RESP) && rsp_ready[owner_q];
  // A new grant is possible from IDLE or in the same cycle the pending result is taken.
  assign grant_fire = !rst && ((state_q == IDLE) || handshake) && (|req_valid);

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign grant_idx = ~req_valid[0];
`else
  assign grant_idx = (&req_valid) ? ~last_q : req_valid[1];
`endif

  assign a_d    = grant_idx ? req1_a    : req0_a;
  assign b_d    = grant_idx ? req1_b    : req0_b;
  assign ctrl_d = grant_idx ? req1_ctrl : req0_ctrl;
  assign fu_d   = grant_idx ? req1_fu   : req0_fu;

  assign req_ready  = grant_fire ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign flags_nzcv = flags_q;

  assign alu_a     = (state_q == EXEC) ? a_q    : '0;
  assign alu_b     = (state_q == EXEC) ? b_q    : '0;
  assign alu_ctrl  = (state_q == EXEC) ? ctrl_q : 4'b0000;
  assign alu_fu    = (state_q == EXEC) ? fu_q   : 1'b0;
  assign alu_cin   = flags_q[1];
  assign alu_vflag = flags_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= 4'b0000;
      fu_q         <= 1'b0;
      owner_q      <= 1'b0;
      flags_q      <= 4'b0000;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      if (grant_fire) begin
        a_q     <= a_d;
        b_q     <= b_d;
        ctrl_q  <= ctrl_d;
        fu_q    <= fu_d;
        owner_q <= grant_idx;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        last_q  <= grant_idx;
`endif
      end
      case (state_q)
        IDLE: if (grant_fire) state_q <= EXEC;
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_cout_q   <= alu_cout;
          // Flags land here so an op granted at the next handshake already sees them.
          if (fu_q) flags_q <= {alu_n, alu_z, alu_c, alu_v};
          state_q <= RESP;
        end
        RESP: if (handshake) state_q <= grant_fire ? EXEC : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: stands in for the ALU, runs directed
// vectors, multi-cycle corner sequences and a randomized run against a reference model.
module tb_alu_share_ctrl;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        req0_fu, req1_fu;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_cout, alu_fu, alu_cin, alu_vflag;
  logic [3:0]  alu_ctrl, flags_nzcv;
  logic        alu_cout, alu_n, alu_z, alu_c, alu_v;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl), .req0_fu(req0_fu), .req1_fu(req1_fu),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_fu(alu_fu),
    .alu_cin(alu_cin), .alu_vflag(alu_vflag),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flags_nzcv(flags_nzcv)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic [3:0]  nzcv;
  } alu_out_t;

  function automatic alu_out_t alu_fn(logic [3:0] ctrl, logic [31:0] a, logic [31:0] b, logic cin);
    alu_out_t    o;
    logic [32:0] s;
    logic [31:0] bb;
    logic        arith;
    bb = b;
    arith = 1'b1;
    case (ctrl)
      OP_ADD: s = {1'b0, a} + {1'b0, b};
      OP_ADC: s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      OP_SUB: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 33'd1; end
      OP_AND: begin arith = 1'b0; s = {1'b0, a & b}; end
      OP_ORR: begin arith = 1'b0; s = {1'b0, a | b}; end
      default: begin arith = 1'b0; s = {1'b0, a ^ b}; end
    endcase
    o.res  = s[31:0];
    o.cout = arith & s[32];
    o.nzcv = {s[31], (s[31:0] == 32'd0), arith & s[32],
              arith & (a[31] == bb[31]) & (s[31] != a[31])};
    return o;
  endfunction

  // Combinational ALU stand-in answering whatever the controller drives.
  alu_out_t alu_o;
  always_comb alu_o = alu_fn(alu_ctrl, alu_a, alu_b, alu_cin);
  assign alu_result = alu_o.res;
  assign alu_cout   = alu_o.cout;
  assign {alu_n, alu_z, alu_c, alu_v} = alu_o.nzcv;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(int port, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic f);
    if (port == 0) begin
      req0_ctrl = c; req0_a = a; req0_b = b; req0_fu = f; req_valid[0] = 1'b1;
    end else begin
      req1_ctrl = c; req1_a = a; req1_b = b; req1_fu = f; req_valid[1] = 1'b1;
    end
  endtask

  // Returns at the falling edge of the cycle in which a grant is seen.
  task automatic wait_grant(string name);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 20), 64'd1);
  endtask

  task automatic do_op(int port, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic f,
                       output logic [31:0] res, output logic cout, output logic [3:0] flg);
    logic [1:0] oh;
    oh = (port == 0) ? 2'b01 : 2'b10;
    drive(port, c, a, b, f);
    wait_grant("op_grant_timeout");
    check("op_req_ready_T", req_ready, oh);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("op_alu_a_T1", alu_a, a);
    check("op_rsp_valid_T1", rsp_valid, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("op_rsp_valid_T2", rsp_valid, oh);
    res = rsp_result;
    cout = rsp_cout;
    flg = flags_nzcv;
    @(posedge clk); #1;
  endtask

  task automatic t_reset_state();
    do_reset();
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_flags", flags_nzcv, 4'b0000);
    check("rst_result", {rsp_cout, rsp_result}, 33'd0);
    check("rst_alu_ops", {alu_a, alu_b, alu_ctrl, alu_fu, alu_cin, alu_vflag}, 71'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        fu;
    logic [31:0] res;
    logic        cout;
    logic [3:0]  flags;
  } vec_t;

  task automatic t_table();
    vec_t vecs[8];
    logic [31:0] r;
    logic        c;
    logic [3:0]  f;
    vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b1, 4'b0110};
    vecs[1] = '{OP_SUB, 32'h5,         32'h3,         1'b0, 32'h2,         1'b1, 4'b0110};
    vecs[2] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0,         1'b1, 4'b0111};
    vecs[3] = '{OP_ADC, 32'h1,         32'h1,         1'b0, 32'h3,         1'b0, 4'b0111};
    vecs[4] = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 4'b1000};
    vecs[5] = '{OP_SUB, 32'h3,         32'h5,         1'b1, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    vecs[6] = '{OP_ADC, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h7FFF_FFFF, 1'b0, 4'b0000};
    vecs[7] = '{OP_ADD, 32'h7FFF_FFFF, 32'h1,         1'b1, 32'h8000_0000, 1'b0, 4'b1001};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_op(i % 2, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].fu, r, c, f);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_cout", i), c, vecs[i].cout);
      check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
      $display("[TB] vec%0d ctrl=%b a=%h b=%h fu=%b -> result=%h cout=%b flags=%b",
               i, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].fu, r, c, f);
    end
  endtask

  task automatic t_adc_chain();
    do_reset();
    drive(0, OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_grant("adc_grant1_timeout");
    check("adc_grant1", req_ready, 2'b01);
    @(posedge clk); #1;
    drive(0, OP_ADC, 32'h1, 32'h1, 1'b0);
    @(negedge clk);
    check("adc_exec_no_grant", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("adc_op1_valid", rsp_valid, 2'b01);
    check("adc_op1_result", {rsp_cout, rsp_result}, {1'b1, 32'h0});
    check("adc_op1_flags", flags_nzcv, 4'b0111);
    check("adc_grant2_at_hs", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("adc_op2_cin_vflag", {alu_cin, alu_vflag, alu_ctrl, alu_fu}, {2'b11, OP_ADC, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("adc_op2_valid", rsp_valid, 2'b01);
    check("adc_op2_result", {rsp_cout, rsp_result}, {1'b0, 32'h3});
    $display("[TB] adc chain: op2 result=%h flags=%b", rsp_result, flags_nzcv);
    @(posedge clk); #1;
  endtask

  task automatic t_round_robin();
    int ng = 0;
    int last_c = 0;
    logic exp_g;
    do_reset();
    drive(0, OP_SUB, 32'h5, 32'h3, 1'b0);
    drive(1, OP_SUB, 32'h5, 32'h3, 1'b0);
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) check("rr_result", rsp_result, 32'h2);
      if (req_ready != 2'b00) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = ng[0];
`endif
        check("rr_grant", req_ready, exp_g ? 2'b10 : 2'b01);
        if (ng > 0) check("rr_interval", 64'(c - last_c), 64'd2);
        $display("[TB] rr grant %0d -> requester %0d", ng, req_ready[1]);
        last_c = c;
        ng++;
      end
      @(posedge clk); #1;
    end
    check("rr_grant_count", 64'(ng), 64'd6);
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("rr_flags_unchanged", flags_nzcv, 4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic t_backpressure();
    do_reset();
    rsp_ready = 2'b01;
    drive(1, OP_ADD, 32'h10, 32'h20, 1'b0);
    wait_grant("bp_grant_timeout");
    check("bp_grant1", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drive(0, OP_SUB, 32'h5, 32'h3, 1'b0);
    @(negedge clk);
    check("bp_exec_no_grant", req_ready, 2'b00);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 2'b10);
      check("bp_hold_result", rsp_result, 32'h30);
      check("bp_hold_no_grant", req_ready, 2'b00);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_grant", req_ready, 2'b01);
    check("bp_release_valid", rsp_valid, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_op2_valid", rsp_valid, 2'b01);
    check("bp_op2_result", rsp_result, 32'h2);
    $display("[TB] backpressure: second result=%h", rsp_result);
    @(posedge clk); #1;
  endtask

  task automatic t_reset_in_exec();
    do_reset();
    drive(0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    wait_grant("rx_grant_timeout");
    check("rx_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_flags", flags_nzcv, 4'b0000);
    check("rx_rsp_valid", rsp_valid, 2'b00);
    check("rx_result", {rsp_cout, rsp_result}, 33'd0);
    check("rx_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rx_no_stale", {rsp_valid, flags_nzcv}, 6'd0);
    end
    $display("[TB] reset during EXEC: flags=%b rsp_valid=%b", flags_nzcv, rsp_valid);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        cout;
    logic [3:0]  flags;
    int          ready_at;
  } exp_t;

  task automatic t_random();
    logic [3:0]  p_ctrl[2];
    logic [31:0] p_a[2], p_b[2];
    logic        p_fu[2];
    logic [3:0]  ops[5];
    logic [1:0]  granted, exp_g;
    logic [3:0]  m_flags;
    logic        m_last, idx, busy;
    alu_out_t    o;
    exp_t        q[$];
    int          n_rsp = 0;
    ops = '{OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_ORR};
    do_reset();
    m_flags = 4'b0000;
    m_last = 1'b1;
    granted = 2'b00;
    for (int p = 0; p < 2; p++) begin
      p_ctrl[p] = OP_ADD; p_a[p] = 32'd0; p_b[p] = 32'd0; p_fu[p] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (granted[p] || !req_valid[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            p_ctrl[p] = ops[$urandom_range(0, 4)];
            p_a[p] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            p_b[p] = $urandom;
            p_fu[p] = 1'($urandom_range(0, 1));
            drive(p, p_ctrl[p], p_a[p], p_b[p], p_fu[p]);
          end else begin
            req_valid[p] = 1'b0;
          end
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      busy = 1'b0;
      if (q.size() != 0) begin
        if (cyc >= q[0].ready_at) begin
          check("rnd_rsp_valid", rsp_valid, q[0].owner ? 2'b10 : 2'b01);
          check("rnd_rsp_data", {rsp_cout, rsp_result}, {q[0].cout, q[0].res});
          check("rnd_flags", flags_nzcv, q[0].flags);
          if (rsp_ready[q[0].owner]) begin
            n_rsp++;
            void'(q.pop_front());
          end else begin
            busy = 1'b1;
          end
        end else begin
          check("rnd_rsp_early", rsp_valid, 2'b00);
          busy = 1'b1;
        end
      end else begin
        check("rnd_rsp_idle", rsp_valid, 2'b00);
      end
      exp_g = 2'b00;
      if (!busy && req_valid != 2'b00) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        idx = ~req_valid[0];
`else
        idx = (req_valid == 2'b11) ? ~m_last : req_valid[1];
`endif
        exp_g = idx ? 2'b10 : 2'b01;
        o = alu_fn(p_ctrl[idx], p_a[idx], p_b[idx], m_flags[1]);
        if (p_fu[idx]) m_flags = o.nzcv;
        q.push_back('{owner: idx, res: o.res, cout: o.cout, flags: m_flags, ready_at: cyc + 2});
        m_last = idx;
      end
      check("rnd_grant", req_ready, exp_g);
      granted = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("rnd_drain", rsp_valid, 2'b00);
    $display("[TB] random run: %0d responses checked", n_rsp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_ctrl = '0; req1_ctrl = '0; req0_fu = 1'b0; req1_fu = 1'b0;
    t_reset_state();
    t_table();
    t_adc_chain();
    t_round_robin();
    t_backpressure();
    t_reset_in_exec();
    t_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
